// File: rtl/vram_text_writer_if.sv
// vram_text_writer_if: character input handshake plus VRAM write port and cursor.
interface vram_text_writer_if #(
   parameter int ADDR_W = 11
);
   logic [7:0]        char_i;
   logic              char_valid_i;
   logic              char_ready_o;
   logic              vram_cea_o;
   logic [ADDR_W-1:0] vram_ada_o;
   logic [7:0]        vram_din_o;
   logic [5:0]        cursor_col_o;
   logic [4:0]        cursor_row_o;
   modport master (
      output char_i, char_valid_i,
      input  char_ready_o, vram_cea_o, vram_ada_o, vram_din_o, cursor_col_o, cursor_row_o
   );
   modport slave (
      input  char_i, char_valid_i,
      output char_ready_o, vram_cea_o, vram_ada_o, vram_din_o, cursor_col_o, cursor_row_o
   );
endinterface

// File: rtl/vram_text_writer.sv
// vram_text_writer: byte-stream text console driving character-cell writes into LCD VRAM.
module vram_text_writer #(
   parameter int          COLS   = 60,
   parameter int          ROWS   = 17,
   parameter int          ADDR_W = 11,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input logic               clk_i,
   input logic               rst_i,
   vram_text_writer_if.slave bus
);
   typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;
   localparam logic [5:0] LAST_COL = 6'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   state_t            state, state_n;
   logic [ADDR_W:0]   cnt, cnt_n, limit;
   logic [ADDR_W-1:0] base, base_n, ada, ada_n, cur_addr, adv_base;
   logic [5:0]        col, col_n;
   logic [4:0]        row, row_n, adv_row;
   logic [7:0]        din, din_n, ch;
   logic              cea, cea_n, ready, ready_n, accept, printable, advance;
   assign ch        = bus.char_i;
   assign accept    = ready && bus.char_valid_i;
   assign printable = ch >= 8'h20 && ch <= 8'h7E;
   assign cur_addr  = base + ADDR_W'(col);
   assign adv_row   = row == LAST_ROW ? '0 : row + 5'd1;
   assign adv_base  = row == LAST_ROW ? '0 : base + ADDR_W'(COLS);
   assign limit     = state == CLR_ALL ? (ADDR_W+1)'(COLS * ROWS) : (ADDR_W+1)'(COLS);
   assign advance   = accept && (ch == 8'h0A || (printable && col == LAST_COL));
   // Clears walk base+cnt; ready only rises the cycle after the final clear write.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      col_n   = col;
      row_n   = row;
      base_n  = base;
      cea_n   = 1'b0;
      ada_n   = ada;
      din_n   = din;
      ready_n = ready;
      if (state != IDLE) begin
         if (cnt == limit) begin
            state_n = IDLE;
            ready_n = 1'b1;
         end else begin
            cea_n = 1'b1;
            ada_n = base + cnt[ADDR_W-1:0];
            din_n = BLANK;
            cnt_n = cnt + (ADDR_W+1)'(1);
         end
      end else if (advance) begin
         col_n   = '0;
         row_n   = adv_row;
         base_n  = adv_base;
         state_n = CLR_LINE;
         ready_n = 1'b0;
         cea_n   = 1'b1;
         ada_n   = printable ? cur_addr : adv_base;
         din_n   = printable ? ch : BLANK;
         cnt_n   = printable ? '0 : (ADDR_W+1)'(1);
      end else if (accept && printable) begin
         cea_n = 1'b1;
         ada_n = cur_addr;
         din_n = ch;
         col_n = col + 6'd1;
      end else if (accept && ch == 8'h08 && col != '0) begin
         col_n = col - 6'd1;
         cea_n = 1'b1;
         ada_n = cur_addr - ADDR_W'(1);
         din_n = BLANK;
      end else if (accept && ch == 8'h0D) begin
         col_n = '0;
      end else if (accept && ch == 8'h0C) begin
         state_n = CLR_ALL;
         ready_n = 1'b0;
         col_n   = '0;
         row_n   = '0;
         base_n  = '0;
         cea_n   = 1'b1;
         ada_n   = '0;
         din_n   = BLANK;
         cnt_n   = (ADDR_W+1)'(1);
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= CLR_ALL;
         cnt   <= '0;
         col   <= '0;
         row   <= '0;
         base  <= '0;
         cea   <= 1'b0;
         ada   <= '0;
         din   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         col   <= col_n;
         row   <= row_n;
         base  <= base_n;
         cea   <= cea_n;
         ada   <= ada_n;
         din   <= din_n;
         ready <= ready_n;
      end
   end
   assign bus.char_ready_o = ready;
   assign bus.vram_cea_o   = cea;
   assign bus.vram_ada_o   = ada;
   assign bus.vram_din_o   = din;
   assign bus.cursor_col_o = col;
   assign bus.cursor_row_o = row;
endmodule
